spi_pwm_multi_driver: RTL



---
 rtl/spi_pwm_pkg.sv | 20 ++
 rtl/spi_pwm_spi_slave.sv | 175 +++++++++++++++++
 rtl/spi_pwm_multi_driver.sv | 114 +++++++++++
 3 files changed

// File: rtl/spi_pwm_pkg.sv
// Shared constants and FSM state type for the SPI-controlled PWM driver.
package spi_pwm_pkg;

    localparam logic [4:0] ADDR_PERIOD = 5'h1E;
    localparam logic [4:0] ADDR_CTRL   = 5'h1F;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_SYNC     = 1;

    // Wide enough for both the 8-bit command and the largest data word
    localparam int SHIFT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_e;

endpackage

// File: rtl/spi_pwm_spi_slave.sv
// SPI mode-0 slave: pin synchronisers, frame FSM, register write port.
// Readback shifter exists only when SPI_PWM_READBACK_EN is defined.
module spi_pwm_spi_slave
    import spi_pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             wr_en_o,
    output logic [4:0]       addr_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [4:0]       rd_addr_o,
    input  logic [WIDTH-1:0] rdata_i
);

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= '0;
            cs_q   <= 2'b11;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            cs_q   <= {cs_q[0], cs_n_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    logic cs_s, mosi_s, rise;
    assign cs_s   = cs_q[1];
    assign mosi_s = mosi_q[1];
    assign rise   = sclk_q[1] & ~sclk_q[2];

    spi_state_e         state_q, state_d;
    logic [4:0]         bitcnt_q, bitcnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d, shin;
    logic               cmd_wr_q, cmd_wr_d;
    logic [4:0]         addr_q, addr_d;
    logic [4:0]         waddr_q, waddr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               wr_en_q, wr_en_d;
    logic               armed_q, armed_d;

    assign shin = {shift_q[SHIFT_W-2:0], mosi_s};

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wr_en_d  = 1'b0;
        // A frame may only start after cs_n has been seen high since reset
        armed_d  = armed_q | cs_s;
        unique case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                shift_d  = '0;
                if (!cs_s && armed_q) state_d = CMD;
            end
            CMD: if (rise) begin
                shift_d  = shin;
                bitcnt_d = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'd7) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    cmd_wr_d = shin[CMD_WRITE_BIT];
                    addr_d   = shin[4:0];
                end
            end
            DATA: if (rise) begin
                shift_d  = shin;
                bitcnt_d = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'(WIDTH - 1)) begin
                    bitcnt_d = '0;
                    shift_d  = '0;
                    wr_en_d  = cmd_wr_q;
                    wdata_d  = shin[WIDTH-1:0];
                    waddr_d  = addr_q;
                    addr_d   = addr_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cs_s) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            cmd_wr_q <= 1'b0;
            addr_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wr_en_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            cmd_wr_q <= cmd_wr_d;
            addr_q   <= addr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wr_en_q  <= wr_en_d;
            armed_q  <= armed_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign addr_o    = waddr_q;
    assign wdata_o   = wdata_q;
    assign rd_addr_o = addr_q;

`ifdef SPI_PWM_READBACK_EN
    logic             fall;
    logic [WIDTH-1:0] osh_q, osh_d;
    logic             ld_q, ld_d;

    assign fall = ~sclk_q[1] & sclk_q[2];

    // Load is armed at a word boundary and taken on the following fall
    always_comb begin
        osh_d = osh_q;
        ld_d  = ld_q;
        if (state_q == IDLE) begin
            osh_d = '0;
            ld_d  = 1'b0;
        end else begin
            if (rise && state_q == CMD && bitcnt_q == 5'd7)
                ld_d = ~shin[CMD_WRITE_BIT];
            else if (rise && state_q == DATA && bitcnt_q == 5'(WIDTH - 1))
                ld_d = ~cmd_wr_q;
            if (fall) begin
                if (ld_q) begin
                    osh_d = rdata_i;
                    ld_d  = 1'b0;
                end else begin
                    osh_d = {osh_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            osh_q <= '0;
            ld_q  <= 1'b0;
        end else begin
            osh_q <= osh_d;
            ld_q  <= ld_d;
        end
    end

    assign miso_o = osh_q[WIDTH-1];
`else
    logic rdata_unused;
    assign rdata_unused = ^rdata_i;
    assign miso_o       = 1'b0;
`endif

endmodule

// File: rtl/spi_pwm_multi_driver.sv
// Multi-channel PWM with SPI register access and shadow/active buffering.
// Define SPI_PWM_READBACK_EN to enable register readback on miso.
module spi_pwm_multi_driver
    import spi_pwm_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic [CHANNELS-1:0] pwm_out
);

    logic             wr_en;
    logic [4:0]       waddr, rd_addr;
    logic [WIDTH-1:0] wdata, rdata;

    spi_pwm_spi_slave #(.WIDTH(WIDTH)) u_spi (
        .clk       (clk),
        .reset     (reset),
        .sclk_i    (sclk),
        .cs_n_i    (cs_n),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .wr_en_o   (wr_en),
        .addr_o    (waddr),
        .wdata_o   (wdata),
        .rd_addr_o (rd_addr),
        .rdata_i   (rdata)
    );

    localparam logic [WIDTH-1:0] PERIOD_RST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0]    duty_sh_q  [CHANNELS];
    logic [WIDTH-1:0]    duty_sh_d  [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [WIDTH-1:0]    duty_act_d [CHANNELS];
    logic [WIDTH-1:0]    period_sh_q, period_sh_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                en_q, en_d, sync_q, sync_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                wrap;

    always_comb begin
        duty_sh_d    = duty_sh_q;
        duty_act_d   = duty_act_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        en_d         = en_q;
        sync_d       = sync_q;
        // >= also recovers a counter stranded above a shrunken period
        wrap  = cnt_q >= period_act_q;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++)
                if (waddr == 5'(i)) duty_sh_d[i] = wdata;
            if (waddr == ADDR_PERIOD) period_sh_d = wdata;
            if (waddr == ADDR_CTRL) begin
                en_d   = wdata[CTRL_EN];
                sync_d = wdata[CTRL_SYNC];
            end
        end
        // Old shadow is taken on a wrap coinciding with a write
        if (!sync_q || wrap) begin
            duty_act_d   = duty_sh_q;
            period_act_d = period_sh_q;
        end
        for (int i = 0; i < CHANNELS; i++)
            pwm_d[i] = en_q && (cnt_q < duty_act_q[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            period_sh_q  <= PERIOD_RST;
            period_act_q <= PERIOD_RST;
            cnt_q        <= '0;
            en_q         <= 1'b1;
            sync_q       <= 1'b1;
            pwm_q        <= '0;
        end else begin
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            sync_q       <= sync_d;
            pwm_q        <= pwm_d;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (rd_addr == 5'(i)) rdata = duty_sh_q[i];
        if (rd_addr == ADDR_PERIOD) rdata = period_sh_q;
        if (rd_addr == ADDR_CTRL) begin
            rdata[CTRL_EN]   = en_q;
            rdata[CTRL_SYNC] = sync_q;
        end
    end

    assign pwm_out = pwm_q;

endmodule
